// File: rtl/uart_tx_core_if.sv
// Avalon-MM slave bus bundle for uart_tx_core: 4-bit address, 8-bit data,
// single-cycle read/write strobes, registered read data.
interface uart_tx_core_if;
  logic [3:0] avms_address_i;
  logic       avms_read_i;
  logic       avms_write_i;
  logic [7:0] avms_writedata_i;
  logic [7:0] avms_readdata_o;

  modport slave (
    input  avms_address_i,
    input  avms_read_i,
    input  avms_write_i,
    input  avms_writedata_i,
    output avms_readdata_o
  );

  modport master (
    output avms_address_i,
    output avms_read_i,
    output avms_write_i,
    output avms_writedata_i,
    input  avms_readdata_o
  );
endinterface

// File: rtl/uart_tx_core.sv
// Transmit-only UART: 10-bit frames (start, 8 data, stop) from a polled register map.
// Data order is MSB first unless UART_LSB_FIRST_EN is defined (then LSB first).
module uart_tx_core #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic           clk_i,
  input  logic           arst_i,
  uart_tx_core_if.slave  avms,
  output logic           uart_txd_o
);

  localparam int unsigned DIV_RAW = CLK_FREQ / BAUD_RATE;
  localparam int unsigned DIV     = (DIV_RAW > 0) ? DIV_RAW : 1;
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       txdata_q, txdata_d;
  logic [7:0]       readdata_q, readdata_d;
  logic             txd_q, txd_d;

  logic tx_ready;
  logic baud_end;
  logic accept;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    txdata_d   = txdata_q;
    readdata_d = readdata_q;

    tx_ready = (state_q == IDLE);
    baud_end = (baud_q == BAUD_LAST);
    accept   = avms.avms_write_i && (avms.avms_address_i == ADDR_TXDATA) && tx_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          shift_d  = avms.avms_writedata_i;
          txdata_d = avms.avms_writedata_i;
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = bit_q + 1'b1;
`ifdef UART_LSB_FIRST_EN
          shift_d = {1'b0, shift_q[7:1]};
`else
          shift_d = {shift_q[6:0], 1'b0};
`endif
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reads sample pre-edge state, so a read alongside an accepted write sees the old values.
    if (avms.avms_read_i) begin
      unique case (avms.avms_address_i)
        ADDR_TXDATA: readdata_d = txdata_q;
        ADDR_STATUS: readdata_d = {7'b0, tx_ready};
        default:     readdata_d = '0;
      endcase
    end

    // Line level is registered from the next state so the pin is glitch-free.
    unique case (state_d)
      START: txd_d = 1'b0;
`ifdef UART_LSB_FIRST_EN
      DATA:  txd_d = shift_d[0];
`else
      DATA:  txd_d = shift_d[7];
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txdata_q   <= '0;
      readdata_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txdata_q   <= txdata_d;
      readdata_q <= readdata_d;
      txd_q      <= txd_d;
    end
  end

  assign avms.avms_readdata_o = readdata_q;
  assign uart_txd_o           = txd_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: frames compared cycle-by-cycle against an
// arithmetic frame model; register reads against the register-map rules.
module tb_uart_tx_core;

  localparam int CF  = 1_300_000;
  localparam int BR  = 100_000;
  localparam int DIV = CF / BR;     // 13 clocks per bit
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic txd;

  int chk = 0;
  int err = 0;
  logic [7:0] last_byte = 8'h00;

  uart_tx_core_if bus ();

  uart_tx_core #(.CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .avms       (bus),
    .uart_txd_o (txd)
  );

  always #5 clk = ~clk;

  // Expected line level c clocks into a frame: start bit, 8 data bits, stop bit.
  function automatic logic exp_txd(logic [7:0] b, int c);
    int k;
    k = c / DIV;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
`ifdef UART_LSB_FIRST_EN
    return b[k - 1];
`else
    return b[8 - k];
`endif
  endfunction

  task automatic idle_bus();
    bus.avms_read_i  = 1'b0;
    bus.avms_write_i = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.avms_address_i = a;
    bus.avms_read_i    = 1'b1;
    @(negedge clk);
    idle_bus();
    d = bus.avms_readdata_o;
  endtask

  // Write issued at a negedge; returns at the negedge following the accepting edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] b);
    bus.avms_address_i   = a;
    bus.avms_writedata_i = b;
    bus.avms_write_i     = 1'b1;
    @(negedge clk);
    idle_bus();
  endtask

  // Called at the negedge just after an accepted write; ends at negedge FRAME.
  task automatic check_frame(input logic [7:0] b, input bit inject_busy);
    for (int c = 0; c < FRAME; c++) begin
      idle_bus();
      chk++;
      if (txd !== exp_txd(b, c)) begin
        err++;
        $display("FAIL frame_bit byte=%02h cyc=%0d txd=%b exp=%b", b, c, txd, exp_txd(b, c));
      end
      if (c == 3) begin
        chk++;
        if (bus.avms_readdata_o !== 8'h00) begin
          err++;
          $display("FAIL status_busy got=%02h exp=00", bus.avms_readdata_o);
        end
      end
      if (c == 2 || c == FRAME - 1) begin
        bus.avms_address_i = 4'h1;
        bus.avms_read_i    = 1'b1;
      end
      if (inject_busy && c == 5 * DIV + 3) begin
        bus.avms_address_i   = 4'h0;
        bus.avms_writedata_i = 8'h89;
        bus.avms_write_i     = 1'b1;
      end
      @(negedge clk);
    end
    idle_bus();
    chk++;
    if (bus.avms_readdata_o !== 8'h00 || txd !== 1'b1) begin
      err++;
      $display("FAIL frame_end status=%02h txd=%b exp 00/1", bus.avms_readdata_o, txd);
    end
    last_byte = b;
  endtask

  task automatic send_checked(input logic [7:0] b);
    logic [7:0] d;
    rd(4'h1, d);
    chk++;
    if (d !== 8'h01) begin
      err++;
      $display("FAIL status_ready_pre got=%02h exp=01", d);
    end
    wr(4'h0, b);
    check_frame(b, 1'b0);
  endtask

  task automatic wait_ready(input int budget);
    logic [7:0] d;
    int n;
    n = 0;
    d = 8'h00;
    while (d[0] !== 1'b1 && n < budget) begin
      rd(4'h1, d);
      n++;
    end
    chk++;
    if (d[0] !== 1'b1) begin
      err++;
      $display("FAIL wait_ready timeout status=%02h exp=01", d);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    idle_bus();
    bus.avms_address_i   = 4'h0;
    bus.avms_writedata_i = 8'h00;
    repeat (3) @(negedge clk);
    chk++;
    if (txd !== 1'b1 || bus.avms_readdata_o !== 8'h00) begin
      err++;
      $display("FAIL reset_values txd=%b rd=%02h exp 1/00", txd, bus.avms_readdata_o);
    end
    arst = 1'b0;
    @(negedge clk);
    rd(4'h1, d);
    chk++;
    if (d !== 8'h01) begin
      err++;
      $display("FAIL reset_status got=%02h exp=01", d);
    end
    rd(4'h7, d);
    chk++;
    if (d !== 8'h00) begin
      err++;
      $display("FAIL unmapped_read got=%02h exp=00", d);
    end
    wr(4'h1, 8'hA5);
    wr(4'h3, 8'h5A);
    for (int i = 0; i < 2 * DIV; i++) begin
      chk++;
      if (txd !== 1'b1) begin
        err++;
        $display("FAIL ignored_write_txd cyc=%0d txd=%b exp=1", i, txd);
      end
      @(negedge clk);
    end
    rd(4'h1, d);
    chk++;
    if (d !== 8'h01) begin
      err++;
      $display("FAIL ignored_write_status got=%02h exp=01", d);
    end
  endtask

  task automatic test_single_and_busy();
    logic [7:0] d;
    rd(4'h1, d);
    wr(4'h0, 8'h48);
    check_frame(8'h48, 1'b1);
    rd(4'h1, d);
    chk++;
    if (d !== 8'h01) begin
      err++;
      $display("FAIL status_after_frame got=%02h exp=01", d);
    end
    for (int i = 0; i < 3 * DIV; i++) begin
      chk++;
      if (txd !== 1'b1) begin
        err++;
        $display("FAIL no_second_frame cyc=%0d txd=%b exp=1", i, txd);
      end
      @(negedge clk);
    end
    rd(4'h0, d);
    chk++;
    if (d !== 8'h48) begin
      err++;
      $display("FAIL txdata_readback got=%02h exp=48", d);
    end
  endtask

  task automatic test_simul_rw();
    logic [7:0] prev;
    prev = last_byte;
    bus.avms_address_i   = 4'h0;
    bus.avms_writedata_i = 8'h3C;
    bus.avms_write_i     = 1'b1;
    bus.avms_read_i      = 1'b1;
    @(negedge clk);
    idle_bus();
    chk++;
    if (bus.avms_readdata_o !== prev) begin
      err++;
      $display("FAIL simul_rw_read got=%02h exp=%02h", bus.avms_readdata_o, prev);
    end
    check_frame(8'h3C, 1'b0);
    wait_ready(4);
  endtask

  task automatic test_sequence();
    logic [7:0] msg [12];
    msg = '{8'h48, 8'h45, 8'h4C, 8'h89, 8'h4F, 8'h5F,
            8'h57, 8'h66, 8'h52, 8'h99, 8'h44, 8'h21};
    for (int i = 0; i < 12; i++) begin
      wait_ready(2 * FRAME);
      send_checked(msg[i]);
    end
    for (int i = 0; i < 6; i++) begin
      wait_ready(2 * FRAME);
      send_checked(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    wait_ready(2 * FRAME);
    wr(4'h0, a);
    check_frame(a, 1'b0);
    // tx_ready rose at the edge before this negedge; write for the very next edge.
    wr(4'h0, b);
    check_frame(b, 1'b0);
    wait_ready(4);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic [7:0] b;
    wr(4'h0, 8'hC3);
    repeat (3 * DIV + 4) @(negedge clk);
    arst = 1'b1;
    #1;
    chk++;
    if (txd !== 1'b1 || bus.avms_readdata_o !== 8'h00) begin
      err++;
      $display("FAIL async_reset txd=%b rd=%02h exp 1/00", txd, bus.avms_readdata_o);
    end
    @(negedge clk);
    arst = 1'b0;
    rd(4'h1, d);
    chk++;
    if (d !== 8'h01 || txd !== 1'b1) begin
      err++;
      $display("FAIL post_reset status=%02h txd=%b exp 01/1", d, txd);
    end
    b = 8'($urandom_range(0, 255));
    wr(4'h0, b);
    check_frame(b, 1'b0);
    wait_ready(4);
  endtask

  initial begin
    bus.avms_address_i   = 4'h0;
    bus.avms_read_i      = 1'b0;
    bus.avms_write_i     = 1'b0;
    bus.avms_writedata_i = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_and_busy();
    test_simul_rw();
    test_sequence();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Transmit-only UART with an 8-bit Avalon-MM slave register interface.
- A CPU or bus master polls a status register and writes bytes to a TX data register.
- The block serialises each byte as a 10-bit frame (start, 8 data, stop) on a single TXD line.
- Sits between the system bus and the board UART pin; there is no receive path.

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate in bit/s. Bit period DIV = CLK_FREQ/BAUD_RATE clocks, integer division (868 at defaults).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- arst_i  in  1  reset, asynchronous, active-high.
- avms_address_i  in  4  register address.
- avms_read_i  in  1  read strobe, one cycle.
- avms_write_i  in  1  write strobe, one cycle.
- avms_writedata_i  in  8  write data.
- avms_readdata_o  out  8  read data, registered.
- uart_txd_o  out  1  serial output, idle high.

Behaviour:
- Reset (arst_i=1, takes effect immediately regardless of clock):
  - uart_txd_o=1, avms_readdata_o=0x00, state IDLE, tx_ready=1, bit and baud counters cleared.
  - Reset mid-frame aborts the frame; line returns high at once.
- Register map (address decoded on all 4 bits):
  - 0x0 TXDATA (write): accepted only when tx_ready=1; ignored while busy. Read returns the last accepted byte.
  - 0x1 STATUS (read-only): bit0=tx_ready (1=idle, can accept a byte), bits7:1=0. Writes ignored.
  - Any other address: reads 0x00, writes ignored.
- Read latency: avms_readdata_o is updated on the rising edge where avms_read_i=1 and holds its value until the next read.
- Write acceptance: on the edge with avms_write_i=1, address 0x0 and tx_ready=1:
  - byte is latched into a shift register;
  - tx_ready drops to 0 on that same edge;
  - state goes to START.
- State machine IDLE -> START -> DATA -> STOP -> IDLE, with a baud counter of DIV clocks per bit:
  - IDLE: txd=1.
  - START: txd=0 for DIV clocks, beginning the cycle after acceptance.
  - DATA: 8 bits, DIV clocks each. Default order is MSB first (bit7 first, bit0 last).
  - STOP: txd=1 for DIV clocks. tx_ready returns to 1 at the end of STOP (10*DIV clocks after START begins). A new write is accepted from that edge onward.
- Simultaneous read and write in one cycle: both are serviced. A STATUS read in the same cycle as an accepted write returns the pre-write value (bit0=1).
- Back-to-back frames: the next START may begin the cycle after tx_ready rises; no extra idle gap is required.
- Baud counter width: ceil(log2(DIV)) bits; it wraps to 0 at DIV-1.

Optional Feature:
- Macro UART_LSB_FIRST_EN.
- When defined: DATA state shifts bit0 first and bit7 last (standard UART order).
- When undefined (default): MSB-first order as specified above.
- Frame timing, register map and status are identical in both cases.

Test Plan:
- Reset then read STATUS (0x1) -> avms_readdata_o=0x01; uart_txd_o=1 throughout.
- Write 0x48 to 0x0 while ready -> txd low for 868 clocks, then data 0,1,0,0,1,0,0,0 (868 clocks each), then stop high. Each bit is checked near the start of its period.
- Poll STATUS during the frame -> 0x00. After 10*868 clocks from START -> 0x01.
- Write 0x89 while busy (mid-frame of 0x48) -> ignored. Frame of 0x48 completes unchanged; no second frame follows.
- Send 12 bytes 48,45,4C,89,4F,5F,57,66,52,99,44,21 using poll-ready/write/poll-busy -> twelve correct frames in order, with txd high between them.
- Assert arst_i mid-data bit -> txd=1 and STATUS=0x01 immediately after reset release. The next write transmits a clean full frame.
- With UART_LSB_FIRST_EN defined, write 0x48 -> data bits sent 0,0,0,1,0,0,1,0.
